// File: rtl/reg_access_if.sv
// Requester-side bus of the shared register bank: flattened per-requester
// request fields plus the arbiter's grant, completion and read-data returns.
interface reg_access_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 2,
    parameter int unsigned NREGS = 4
);
    localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       we;
    logic [NREQ*AW-1:0]    addr;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, ack, rdata
    );
endinterface

// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter that serialises single read/write accesses from NREQ
// requesters into a small register bank through an IDLE/GRANT/COMMIT sequence.
module reg_access_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 2,
    parameter int unsigned NREGS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    reg_access_if.slave            bus,
    input  logic                   clr,
    output logic [NREGS*WIDTH-1:0] regs,
    output logic                   busy
);
    localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int unsigned PW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                           state_q, state_d;
    logic   [NREQ-1:0]                gnt_q, gnt_d;
    logic   [NREQ-1:0]                ack_q, ack_d;
    logic   [PW-1:0]                  win_q, win_d;
    logic   [PW-1:0]                  ptr_q, ptr_d;
    logic   [WIDTH-1:0]               rdata_q;
    logic   [NREGS-1:0][WIDTH-1:0]    regs_q;

    logic                             pick_valid;
    logic   [PW-1:0]                  pick;
    logic                             do_access;
    logic   [AW-1:0]                  addr_a  [NREQ];
    logic   [WIDTH-1:0]               wdata_a [NREQ];
    logic                             we_w;
    logic   [AW-1:0]                  addr_w;
    logic   [WIDTH-1:0]               wdata_w;
    logic                             addr_ok;

    // Unflatten per-requester address and write-data slices.
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_a[i]  = bus.addr[i*AW +: AW];
        assign wdata_a[i] = bus.wdata[i*WIDTH +: WIDTH];
    end

    assign we_w    = bus.we[win_q];
    assign addr_w  = addr_a[win_q];
    assign wdata_w = wdata_a[win_q];
    assign addr_ok = (32'(addr_w) < NREGS);

    // First requesting index at or after the rotation pointer, wrapping.
    always_comb begin
        int unsigned idx;
        pick_valid = 1'b0;
        pick       = '0;
        idx        = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr_q) + k) % NREQ;
            if (!pick_valid && bus.req[PW'(idx)]) begin
                pick_valid = 1'b1;
                pick       = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = '0;
        ack_d     = '0;
        win_d     = win_q;
        ptr_d     = ptr_q;
        do_access = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    win_d   = pick;
                    gnt_d   = NREQ'(1) << pick;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // A requester that withdraws here aborts without moving the pointer.
                if (bus.req[win_q]) begin
                    do_access = 1'b1;
                    ack_d     = NREQ'(1) << win_q;
                    state_d   = COMMIT;
                end else begin
                    state_d = IDLE;
                end
            end
            COMMIT: begin
                ptr_d   = (32'(win_q) == NREQ - 1) ? '0 : win_q + PW'(1);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ack_q   <= '0;
            win_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
        end
    end

    // Register bank: clear outranks a same-edge write; reads see pre-clear data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q  <= '0;
            rdata_q <= '0;
        end else begin
            if (clr) begin
                regs_q <= '0;
            end else if (do_access && we_w && addr_ok) begin
                regs_q[addr_w] <= wdata_w;
            end
            if (do_access && !we_w) begin
                rdata_q <= addr_ok ? regs_q[addr_w] : '0;
            end
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;
    assign regs      = regs_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter: reset, single access, rotation,
// clear collisions, abort and asynchronous reset during a grant.
module tb_reg_access_arbiter;
    logic       clk;
    logic       rst_n;
    logic       clr;
    logic [7:0] regs;
    logic       busy;
    int         errors = 0;
    int         checks = 0;

    reg_access_if #(.NREQ(4), .WIDTH(2), .NREGS(4)) bus ();

    reg_access_arbiter #(.NREQ(4), .WIDTH(2), .NREGS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .clr   (clr),
        .regs  (regs),
        .busy  (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input logic [1:0] i, input logic w, input logic [1:0] a,
                           input logic [1:0] d);
        bus.we[i]                  = w;
        bus.addr[{i, 1'b0} +: 2]   = a;
        bus.wdata[{i, 1'b0} +: 2]  = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) begin
            bus.req   = 4'($urandom);
            bus.we    = 4'($urandom);
            bus.addr  = 8'($urandom);
            bus.wdata = 8'($urandom);
            clr       = 1'($urandom);
            @(negedge clk);
        end
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt); end
        checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got=%b exp=0000", bus.ack); end
        checks++; if (bus.rdata !== 2'b00) begin errors++; $display("FAIL reset_rdata got=%b exp=00", bus.rdata); end
        checks++; if (regs !== 8'h00) begin errors++; $display("FAIL reset_regs got=%h exp=00", regs); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0; clr = 1'b0;
        rst_n = 1'b1;
        repeat (3) cycle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL idle_gnt got=%b exp=0000", bus.gnt); end
    endtask

    task automatic test_single_write();
        set_req(2'd2, 1'b1, 2'd3, 2'b10);
        bus.req = 4'b0100;
        cycle();
        checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL wr_gnt got=%b exp=0100", bus.gnt); end
        checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL wr_ack_early got=%b exp=0000", bus.ack); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy got=%b exp=1", busy); end
        cycle();
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL wr_gnt_clr got=%b exp=0000", bus.gnt); end
        checks++; if (bus.ack !== 4'b0100) begin errors++; $display("FAIL wr_ack got=%b exp=0100", bus.ack); end
        checks++; if (regs !== 8'b10_00_00_00) begin errors++; $display("FAIL wr_regs got=%b exp=10000000", regs); end
        bus.req = 4'b0000;
        cycle();
        checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL wr_ack_pulse got=%b exp=0000", bus.ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_idle got=%b exp=0", busy); end
    endtask

    task automatic test_read_back();
        set_req(2'd1, 1'b0, 2'd3, 2'b00);
        bus.req = 4'b0010;
        cycle();
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL rd_gnt got=%b exp=0010", bus.gnt); end
        cycle();
        checks++; if (bus.ack !== 4'b0010) begin errors++; $display("FAIL rd_ack got=%b exp=0010", bus.ack); end
        checks++; if (bus.rdata !== 2'b10) begin errors++; $display("FAIL rd_data got=%b exp=10", bus.rdata); end
        checks++; if (regs !== 8'b10_00_00_00) begin errors++; $display("FAIL rd_regs got=%b exp=10000000", regs); end
        bus.req = 4'b0000;
        cycle();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_req(2'(i), 1'b1, 2'(i), 2'(i));
        bus.req = 4'b1111;
        for (int c = 1; c <= 14; c++) begin
            cycle();
            exp = (c % 3 == 2) ? (4'b0001 << ((c - 2) / 3 % 4)) : 4'b0000;
            checks++;
            if (bus.ack !== exp) begin
                errors++;
                $display("FAIL rr_ack cycle=%0d got=%b exp=%b", c, bus.ack, exp);
            end
        end
        bus.req = 4'b0000;
        cycle();
        checks++; if (regs !== 8'b11_10_01_00) begin errors++; $display("FAIL rr_regs got=%b exp=11100100", regs); end
        bus.req = 4'b1001;
        cycle();
        checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL rr_ptr_gnt got=%b exp=1000", bus.gnt); end
        cycle();
        checks++; if (bus.ack !== 4'b1000) begin errors++; $display("FAIL rr_ptr_ack got=%b exp=1000", bus.ack); end
        bus.req = 4'b0001;
        cycle();
        cycle();
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL rr_wrap_gnt got=%b exp=0001", bus.gnt); end
        cycle();
        checks++; if (bus.ack !== 4'b0001) begin errors++; $display("FAIL rr_wrap_ack got=%b exp=0001", bus.ack); end
        bus.req = 4'b0000;
        cycle();
    endtask

    task automatic test_clear_collision();
        set_req(2'd0, 1'b1, 2'd0, 2'b11);
        bus.req = 4'b0001;
        cycle();
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL clr_gnt got=%b exp=0001", bus.gnt); end
        clr = 1'b1;
        cycle();
        checks++; if (bus.ack !== 4'b0001) begin errors++; $display("FAIL clr_ack got=%b exp=0001", bus.ack); end
        checks++; if (regs !== 8'h00) begin errors++; $display("FAIL clr_regs got=%b exp=00000000", regs); end
        clr = 1'b0;
        bus.req = 4'b0000;
        cycle();
    endtask

    task automatic test_clear_read();
        set_req(2'd2, 1'b1, 2'd2, 2'b01);
        bus.req = 4'b0100;
        cycle();
        cycle();
        checks++; if (regs !== 8'b00_01_00_00) begin errors++; $display("FAIL clrrd_pre got=%b exp=00010000", regs); end
        bus.req = 4'b0000;
        cycle();
        set_req(2'd1, 1'b0, 2'd2, 2'b00);
        bus.req = 4'b0010;
        cycle();
        clr = 1'b1;
        cycle();
        checks++; if (bus.ack !== 4'b0010) begin errors++; $display("FAIL clrrd_ack got=%b exp=0010", bus.ack); end
        checks++; if (bus.rdata !== 2'b01) begin errors++; $display("FAIL clrrd_data got=%b exp=01", bus.rdata); end
        checks++; if (regs !== 8'h00) begin errors++; $display("FAIL clrrd_regs got=%b exp=00000000", regs); end
        clr = 1'b0;
        bus.req = 4'b0000;
        cycle();
    endtask

    task automatic test_abort();
        set_req(2'd0, 1'b1, 2'd1, 2'b11);
        bus.req = 4'b0001;
        cycle();
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL ab_gnt got=%b exp=0001", bus.gnt); end
        bus.req = 4'b0000;
        cycle();
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL ab_gnt_clr got=%b exp=0000", bus.gnt); end
        checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL ab_ack got=%b exp=0000", bus.ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ab_busy got=%b exp=0", busy); end
        cycle();
        checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL ab_ack_late got=%b exp=0000", bus.ack); end
        checks++; if (regs !== 8'h00) begin errors++; $display("FAIL ab_regs got=%b exp=00000000", regs); end
        set_req(2'd1, 1'b0, 2'd0, 2'b00);
        bus.req = 4'b0011;
        cycle();
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL ab_ptr_gnt got=%b exp=0001", bus.gnt); end
        bus.req = 4'b0000;
        cycle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ab2_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid_grant();
        set_req(2'd0, 1'b1, 2'd0, 2'b11);
        bus.req = 4'b0001;
        cycle();
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL rst_gnt got=%b exp=0001", bus.gnt); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt_async got=%b exp=0000", bus.gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy_async got=%b exp=0", busy); end
        cycle();
        checks++; if (regs !== 8'h00) begin errors++; $display("FAIL rst_regs got=%b exp=00000000", regs); end
        checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL rst_ack got=%b exp=0000", bus.ack); end
        bus.req = 4'b0000;
        rst_n = 1'b1;
        cycle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle got=%b exp=0", busy); end
        checks++; if (regs !== 8'h00) begin errors++; $display("FAIL rst_regs_after got=%b exp=00000000", regs); end
    endtask

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        bus.req   = '0;
        bus.we    = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        test_reset();
        test_single_write();
        test_read_back();
        test_round_robin();
        test_clear_collision();
        test_clear_read();
        test_abort();
        test_reset_mid_grant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
